// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: request record,
// arbiter state encoding and a one-hot helper for the pending-register mask.
package rf_wb_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;
  localparam int NREG  = 1 << RF_AW;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } wb_state_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [RF_AW-1:0] addr);
    logic [NREG-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of secondary writeback results. Per-slot valid bits give
// full/empty directly and let the parent build the pending-register mask.
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  wb_req_t                     push_req_i,
  input  logic                        pop_i,
  output wb_req_t                     head_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [DEPTH-1:0]            ent_valid_o,
  output logic [DEPTH-1:0][RF_AW-1:0] ent_addr_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = &valid_q;
  assign empty_o = ~|valid_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Push and pop can only hit the same slot when full or empty, and the
  // guards above rule both of those out.
  always_comb begin
    valid_d = valid_q;
    if (do_push) valid_d[wptr_q] = 1'b1;
    if (do_pop)  valid_d[rptr_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_req_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_o[i] = mem_q[i].addr;
    end
  end

  assign ent_valid_o = valid_q;
  assign head_o      = mem_q[rptr_q];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges the never-stalled primary writeback and the queued secondary
// writeback onto the single RF write port; tracks pending destinations.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             p_valid_i,
  input  logic [RF_AW-1:0] p_addr_i,
  input  logic [XLEN-1:0]  p_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [RF_AW-1:0] s_addr_i,
  input  logic [XLEN-1:0]  s_data_i,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic [NREG-1:0]  pending_mask_o,
  output logic             stall_req_o,
  output wb_state_e        dbg_state_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // valid/ready: S transfers on a rising edge where s_valid_i & s_ready_o are
  // both high, and holds addr/data stable while valid and not ready. P has no
  // ready: it is taken on every cycle it is valid.
  logic                        s_hs;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        bypass;
  logic                        push;
  logic                        pop;
  wb_req_t                     s_req;
  wb_req_t                     head;
  wb_req_t                     sel;
  logic                        sel_valid;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][RF_AW-1:0] ent_addr;
  logic [NREG-1:0]             mask_d;
  logic [NREG-1:0]             mask_q;
  wb_state_e                   state_q;
  wb_state_e                   state_d;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_d;

  assign s_req     = '{addr: s_addr_i, data: s_data_i};
  assign s_ready_o = ~fifo_full;
  assign s_hs      = s_valid_i & s_ready_o;
  assign pop       = ~p_valid_i & ~fifo_empty;
  assign bypass    = ~p_valid_i & fifo_empty & s_hs;
  assign push      = s_hs & ~bypass & (s_addr_i != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_req_i  (s_req),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    if (p_valid_i) begin
      sel_valid = 1'b1;
      sel       = '{addr: p_addr_i, data: p_data_i};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel       = head;
    end else if (s_hs) begin
      sel_valid = 1'b1;
      sel       = s_req;
    end
  end

  // x0 targets are consumed but never written; nothing reaches the RF in reset.
  assign rf_we_o    = rst_ni & sel_valid & (sel.addr != '0);
  assign rf_waddr_o = rst_ni ? sel.addr : '0;
  assign rf_wdata_o = rst_ni ? sel.data : '0;

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) mask_d = mask_d | reg_onehot(ent_addr[i]);
    end
    mask_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      NORMAL: begin
        if (fifo_empty || pop) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
          cnt_d   = CW'(STARVE_LIMIT);
          state_d = STARVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STARVE: begin
        if (pop) begin
          cnt_d   = '0;
          state_d = NORMAL;
        end else begin
          cnt_d = CW'(STARVE_LIMIT);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign pending_mask_o = mask_q;
  assign stall_req_o    = (state_q == STARVE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: single-cycle vector table plus
// multi-cycle sequences for contention, full, starvation and mid-op reset.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        p_valid = 1'b0;
  logic [4:0]  p_addr  = '0;
  logic [31:0] p_data  = '0;
  logic        s_valid = 1'b0;
  logic [4:0]  s_addr  = '0;
  logic [31:0] s_data  = '0;
  logic        s_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] pending_mask_o;
  logic        stall_req_o;
  wb_state_e   dbg_state_o;

  always #5 clk_i = ~clk_i;

  rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .p_valid_i      (p_valid),
    .p_addr_i       (p_addr),
    .p_data_i       (p_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready_o),
    .s_addr_i       (s_addr),
    .s_data_i       (s_data),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .pending_mask_o (pending_mask_o),
    .stall_req_o    (stall_req_o),
    .dbg_state_o    (dbg_state_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic        we;
    logic        ad;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] mk[9];
  logic [4:0]  cs[3];
  logic [4:0]  fs[5];
  int          s_idx;
  logic        tv;
  logic [4:0]  ta;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    @(negedge clk_i);
    p_valid = pv;
    p_addr  = pa;
    p_data  = pd;
    s_valid = sv;
    s_addr  = sa;
    s_data  = sd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  function automatic logic [31:0] sdat(input logic [4:0] a);
    return 32'h5000_0000 + 32'(a);
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk_i);
    #2;
    if (rst_ni && p_valid) check("waw_pending", {63'd0, pending_mask_o[p_addr]}, 64'd0);
    if (rf_we_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got x%0d=0x%0h, expected no write (t=%0t)",
                 rf_waddr_o, rf_wdata_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rf_write", {27'd0, rf_waddr_o, rf_wdata_o}, {27'd0, mon_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b0, 1'b1, 5'd0,  32'd0};
    vecs[1] = '{1'b1, 5'd1,  32'h1111_1111, 1'b0, 5'd0,  32'd0,         1'b1, 1'b1, 5'd1,  32'h1111_1111};
    vecs[2] = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd0,  32'h1234,      1'b0, 5'd0,  32'd0,         1'b0, 1'b0, 5'd0,  32'd0};
    vecs[4] = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd0,  32'h1234,      1'b0, 1'b0, 5'd0,  32'd0};
    vecs[5] = '{1'b1, 5'd2,  32'hA5,        1'b1, 5'd0,  32'h1234,      1'b1, 1'b1, 5'd2,  32'hA5};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'd0,         1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 5'd0,  32'd0,         1'b1, 5'd31, 32'h0BAD_F00D, 1'b1, 1'b1, 5'd31, 32'h0BAD_F00D};
    vecs[8] = '{1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b0, 1'b1, 5'd0,  32'd0};
    mk = '{32'h0, 32'h0, 32'h08, 32'h18, 32'h98, 32'h98, 32'h90, 32'h80, 32'h0};
    cs = '{5'd3, 5'd4, 5'd7};
    fs = '{5'd1, 5'd2, 5'd6, 5'd8, 5'd9};

    // Reset values, with P driven to show no write leaks through.
    p_valid = 1'b1;
    p_addr  = 5'd9;
    p_data  = 32'h9999;
    #1;
    check("rst_we",     {63'd0, rf_we_o},        64'd0);
    check("rst_waddr",  {59'd0, rf_waddr_o},     64'd0);
    check("rst_wdata",  {32'd0, rf_wdata_o},     64'd0);
    check("rst_sready", {63'd0, s_ready_o},      64'd1);
    check("rst_mask",   {32'd0, pending_mask_o}, 64'd0);
    check("rst_stall",  {63'd0, stall_req_o},    64'd0);
    @(negedge clk_i);
    p_valid = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single-cycle table: FIFO stays empty throughout.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].sv, vecs[i].sa, vecs[i].sd);
      if (vecs[i].we) expect_wr(vecs[i].wa, vecs[i].wd);
      check($sformatf("vec%0d_we", i), {63'd0, rf_we_o}, {63'd0, vecs[i].we});
      if (vecs[i].ad) begin
        check($sformatf("vec%0d_waddr", i), {59'd0, rf_waddr_o}, {59'd0, vecs[i].wa});
        check($sformatf("vec%0d_wdata", i), {32'd0, rf_wdata_o}, {32'd0, vecs[i].wd});
      end
      check($sformatf("vec%0d_sready", i), {63'd0, s_ready_o}, 64'd1);
      check($sformatf("vec%0d_mask", i), {32'd0, pending_mask_o}, 64'd0);
    end

    // Contention: P every cycle while S queues x3,x4,x7; then drain in order.
    for (int k = 0; k < 9; k++) begin
      tv = (k < 3);
      ta = 5'd0;
      if (k < 3) ta = cs[k];
      drive(k < 4, 5'(10 + k), 32'hC000_0000 + 32'(k), tv, ta, sdat(ta));
      if (k < 4) expect_wr(5'(10 + k), 32'hC000_0000 + 32'(k));
      if (k >= 4 && k <= 6) begin
        expect_wr(cs[k-4], sdat(cs[k-4]));
        check("drain_addr", {59'd0, rf_waddr_o}, {59'd0, cs[k-4]});
      end
      check($sformatf("cont_mask%0d", k), {32'd0, pending_mask_o}, {32'd0, mk[k]});
    end

    // Full: P held valid, five S results, the fifth must wait for space.
    s_idx = 0;
    for (int k = 0; k < 12; k++) begin
      tv = (s_idx < 5);
      ta = 5'd0;
      if (s_idx < 5) ta = fs[s_idx];
      drive(k < 6, 5'(20 + k), 32'hF000_0000 + 32'(k), tv, ta, sdat(ta));
      if (k < 6) expect_wr(5'(20 + k), 32'hF000_0000 + 32'(k));
      else if (k <= 10) expect_wr(fs[k-6], sdat(fs[k-6]));
      check($sformatf("full_sready%0d", k), {63'd0, s_ready_o}, {63'd0, (k < 4 || k > 6)});
      check($sformatf("full_stall%0d", k), {63'd0, stall_req_o}, 64'd0);
      if (tv && s_ready_o) s_idx++;
    end
    check("full_all_accepted", 64'(s_idx), 64'd5);

    // Starvation: one queued x12 blocked by P until the stall request fires.
    for (int k = 0; k < 12; k++) begin
      drive(k < 10, 5'(20 + k), 32'hAB00_0000 + 32'(k), k == 0, 5'd12, sdat(5'd12));
      if (k < 10) expect_wr(5'(20 + k), 32'hAB00_0000 + 32'(k));
      if (k == 10) begin
        expect_wr(5'd12, sdat(5'd12));
        check("starve_head_addr", {59'd0, rf_waddr_o}, 64'd12);
      end
      check($sformatf("starve_stall%0d", k), {63'd0, stall_req_o}, {63'd0, (k == 9 || k == 10)});
      check($sformatf("starve_state%0d", k), {63'd0, dbg_state_o == STARVE}, {63'd0, (k == 9 || k == 10)});
    end

    // Reset mid-operation with three results queued.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(20 + k), 32'hEE00_0000 + 32'(k), 1'b1, 5'(3 + k), sdat(5'(3 + k)));
      expect_wr(5'(20 + k), 32'hEE00_0000 + 32'(k));
    end
    @(negedge clk_i);
    rst_ni  = 1'b0;
    p_valid = 1'b1;
    p_addr  = 5'd21;
    s_valid = 1'b0;
    #1;
    check("midrst_we",     {63'd0, rf_we_o},        64'd0);
    check("midrst_sready", {63'd0, s_ready_o},      64'd1);
    check("midrst_mask",   {32'd0, pending_mask_o}, 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    p_valid = 1'b0;
    #1;
    check("postrst_sready", {63'd0, s_ready_o},      64'd1);
    check("postrst_mask",   {32'd0, pending_mask_o}, 64'd0);
    check("postrst_we",     {63'd0, rf_we_o},        64'd0);
    for (int k = 0; k < 6; k++) idle();
    check("postrst_mask_late", {32'd0, pending_mask_o}, 64'd0);

    idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
